// File: rtl/kv_pkg.sv
// Shared definitions for the KV-cache scan/append scheduler: FSM encoding and
// address-width helper.
package kv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } kv_state_e;

    // Address width for a DEPTH-entry cache; never narrower than one bit.
    function automatic int kv_addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/kv_cache_sched.sv
// KV-cache scheduler: appends tokens at the tail of a circular buffer and
// streams a snapshot of the cached entries oldest-first on request.
// Optional macro KV_SCHED_RING_EN enables sliding-window (overwrite-oldest) mode.
module kv_cache_sched
    import kv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    localparam int AW        = kv_addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  app_valid,
    output logic                  app_ready,
    input  logic [DATA_WIDTH-1:0] app_k,
    input  logic [DATA_WIDTH-1:0] app_v,

    input  logic                  clear,

    input  logic                  scan_start,
    output logic                  scan_ready,
    output logic                  scan_done,

    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_k,
    output logic [DATA_WIDTH-1:0] out_v,
    output logic [AW-1:0]         out_idx,

    output logic [AW:0]           count,

    output logic                  kv_wr_en,
    output logic [AW-1:0]         kv_wr_addr,
    output logic [DATA_WIDTH-1:0] kv_k_wr,
    output logic [DATA_WIDTH-1:0] kv_v_wr,

    output logic                  kv_rd_en,
    output logic [AW-1:0]         kv_rd_addr,
    input  logic [DATA_WIDTH-1:0] kv_k_rd,
    input  logic [DATA_WIDTH-1:0] kv_v_rd
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    kv_state_e       state_q,     state_d;
    logic [AW-1:0]   head_q,      head_d;
    logic [AW-1:0]   tail_q,      tail_d;
    logic [AW:0]     count_q,     count_d;
    logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [AW:0]     rd_cnt_q,    rd_cnt_d;
    logic [AW:0]     snap_n_q,    snap_n_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q,  out_last_d;
    logic [AW-1:0]   out_idx_q,   out_idx_d;
    logic            scan_done_q, scan_done_d;

    logic full;
    logic app_acc;
    logic scan_acc;
    logic rd_last;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign full       = (count_q == FULL_CNT);
    assign scan_ready = (state_q == ST_IDLE);
    assign scan_acc   = scan_start && scan_ready;

`ifdef KV_SCHED_RING_EN
    // Overwriting is allowed except while a scan could still read the oldest slot.
    assign app_ready = !clear && !((state_q != ST_IDLE) && full);
`else
    assign app_ready = !clear && !full;
`endif

    assign app_acc    = app_valid && app_ready;
    assign kv_wr_en   = app_acc;
    assign kv_wr_addr = tail_q;
    assign kv_k_wr    = app_k;
    assign kv_v_wr    = app_v;

    assign kv_rd_en   = (state_q == ST_SCAN);
    assign kv_rd_addr = rd_ptr_q;
    assign rd_last    = kv_rd_en && (rd_cnt_q == snap_n_q - 1'b1);

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_idx    = out_idx_q;
    assign out_k      = kv_k_rd;
    assign out_v      = kv_v_rd;
    assign scan_done  = scan_done_q;
    assign count      = count_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        snap_n_d = snap_n_q;

        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (app_acc) begin
            tail_d = next_ptr(tail_q);
`ifdef KV_SCHED_RING_EN
            if (full) head_d = next_ptr(head_q);
            else      count_d = count_q + 1'b1;
`else
            count_d = count_q + 1'b1;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                // The snapshot uses pre-append count, so a same-cycle append is excluded.
                if (scan_acc && !clear && (count_q != '0)) begin
                    state_d  = ST_SCAN;
                    rd_ptr_d = head_q;
                    rd_cnt_d = '0;
                    snap_n_d = count_q;
                end
            end
            ST_SCAN: begin
                rd_ptr_d = next_ptr(rd_ptr_q);
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_last) state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) state_d = ST_IDLE;
    end

    always_comb begin
        out_valid_d = kv_rd_en && !clear;
        out_last_d  = rd_last && !clear;
        out_idx_d   = kv_rd_en ? rd_cnt_q[AW-1:0] : out_idx_q;
        scan_done_d = (rd_last && !clear) || (scan_acc && ((count_q == '0) || clear));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            snap_n_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            snap_n_q    <= snap_n_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            scan_done_q <= scan_done_d;
        end
    end

endmodule

// File: tb/tb_kv_cache_sched.sv
// Directed testbench for kv_cache_sched with a small external cache model;
// build with KV_SCHED_RING_EN to exercise the sliding-window variant.
module tb_kv_cache_sched;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          app_valid, app_ready;
    logic [DW-1:0] app_k, app_v;
    logic          clear;
    logic          scan_start, scan_ready, scan_done;
    logic          out_valid, out_last;
    logic [DW-1:0] out_k, out_v;
    logic [AW-1:0] out_idx;
    logic [AW:0]   count;
    logic          kv_wr_en;
    logic [AW-1:0] kv_wr_addr;
    logic [DW-1:0] kv_k_wr, kv_v_wr;
    logic          kv_rd_en;
    logic [AW-1:0] kv_rd_addr;
    logic [DW-1:0] kv_k_rd, kv_v_rd;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem_k [DEPTH];
    logic [DW-1:0] mem_v [DEPTH];

    always #5 clk = ~clk;

    // External cache: write same cycle, read data one cycle after kv_rd_en.
    always @(posedge clk) begin
        if (kv_wr_en) begin
            mem_k[kv_wr_addr] <= kv_k_wr;
            mem_v[kv_wr_addr] <= kv_v_wr;
        end
        if (kv_rd_en) begin
            kv_k_rd <= mem_k[kv_rd_addr];
            kv_v_rd <= mem_v[kv_rd_addr];
        end
    end

    kv_cache_sched #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .app_valid  (app_valid),
        .app_ready  (app_ready),
        .app_k      (app_k),
        .app_v      (app_v),
        .clear      (clear),
        .scan_start (scan_start),
        .scan_ready (scan_ready),
        .scan_done  (scan_done),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_k      (out_k),
        .out_v      (out_v),
        .out_idx    (out_idx),
        .count      (count),
        .kv_wr_en   (kv_wr_en),
        .kv_wr_addr (kv_wr_addr),
        .kv_k_wr    (kv_k_wr),
        .kv_v_wr    (kv_v_wr),
        .kv_rd_en   (kv_rd_en),
        .kv_rd_addr (kv_rd_addr),
        .kv_k_rd    (kv_k_rd),
        .kv_v_rd    (kv_v_rd)
    );

    task automatic idle_inputs();
        app_valid  = 1'b0;
        app_k      = '0;
        app_v      = '0;
        clear      = 1'b0;
        scan_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        tests_run++; if (count !== 3'd0)   begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++; if (scan_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_scan_ready got %b want 1", scan_ready); end
        tests_run++; if (app_ready !== 1'b1)  begin tests_failed++; $display("FAIL reset_app_ready got %b want 1", app_ready); end
        tests_run++; if ({out_valid, out_last, scan_done, kv_rd_en, kv_wr_en} !== 5'b0)
            begin tests_failed++; $display("FAIL reset_pulses got %b want 00000", {out_valid, out_last, scan_done, kv_rd_en, kv_wr_en}); end
        rst_n = 1'b1;
    endtask

    task automatic test_empty_scan();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        #1;
        tests_run++; if (scan_done !== 1'b1) begin tests_failed++; $display("FAIL empty_scan_done got %b want 1", scan_done); end
        for (int c = 0; c < 3; c++) begin
            tests_run++; if (out_valid !== 1'b0 || kv_rd_en !== 1'b0)
                begin tests_failed++; $display("FAIL empty_scan_quiet c=%0d out_valid=%b rd_en=%b want 0", c, out_valid, kv_rd_en); end
            @(negedge clk); #1;
        end
        tests_run++; if (scan_done !== 1'b0 || scan_ready !== 1'b1)
            begin tests_failed++; $display("FAIL empty_scan_after done=%b ready=%b want 0/1", scan_done, scan_ready); end
    endtask

    task automatic test_append();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            app_valid = 1'b1;
            app_k     = DW'(i + 1);
            app_v     = DW'(16'h100 + i + 1);
            #1;
            tests_run++; if (kv_wr_en !== 1'b1 || kv_wr_addr !== AW'(i))
                begin tests_failed++; $display("FAIL append_wr i=%0d en=%b addr=%0d want 1/%0d", i, kv_wr_en, kv_wr_addr, i); end
        end
        @(negedge clk);
        app_valid = 1'b0;
        #1;
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL append_count got %0d want 3", count); end
    endtask

    task automatic test_scan();
        @(negedge clk);
        scan_start = 1'b1;
        #1;
        tests_run++; if (scan_ready !== 1'b1) begin tests_failed++; $display("FAIL scan_ready_idle got %b want 1", scan_ready); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            #1;
            tests_run++; if (kv_rd_en !== (c <= 3))
                begin tests_failed++; $display("FAIL scan_rd_en c=%0d got %b want %b", c, kv_rd_en, (c <= 3)); end
            if (c <= 3) begin
                tests_run++; if (kv_rd_addr !== AW'(c - 1))
                    begin tests_failed++; $display("FAIL scan_rd_addr c=%0d got %0d want %0d", c, kv_rd_addr, c - 1); end
            end
            tests_run++; if (out_valid !== (c >= 2 && c <= 4))
                begin tests_failed++; $display("FAIL scan_out_valid c=%0d got %b", c, out_valid); end
            if (c >= 2 && c <= 4) begin
                tests_run++; if (out_k !== DW'(c - 1) || out_v !== DW'(16'h100 + c - 1) || out_idx !== AW'(c - 2))
                    begin tests_failed++; $display("FAIL scan_data c=%0d k=%0d v=%h idx=%0d want %0d/%h/%0d", c, out_k, out_v, out_idx, c - 1, 16'h100 + c - 1, c - 2); end
            end
            tests_run++; if (out_last !== (c == 4) || scan_done !== (c == 4))
                begin tests_failed++; $display("FAIL scan_last_done c=%0d last=%b done=%b want %b", c, out_last, scan_done, (c == 4)); end
            tests_run++; if (scan_ready !== (c == 5))
                begin tests_failed++; $display("FAIL scan_ready_busy c=%0d got %b want %b", c, scan_ready, (c == 5)); end
        end
    endtask

    task automatic test_clear_abort();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        #1;
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL abort_before got out_valid=%b want 1", out_valid); end
        @(negedge clk);
        clear = 1'b0;
        #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL abort_count got %0d want 0", count); end
        for (int c = 3; c <= 5; c++) begin
            tests_run++; if ({out_valid, kv_rd_en, out_last, scan_done} !== 4'b0)
                begin tests_failed++; $display("FAIL abort_quiet c=%0d got %b want 0000", c, {out_valid, kv_rd_en, out_last, scan_done}); end
            @(negedge clk); #1;
        end
        tests_run++; if (scan_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_idle got %b want 1", scan_ready); end
    endtask

    task automatic test_clear_priority();
        @(negedge clk);
        app_valid = 1'b1;
        app_k     = 16'hBEEF;
        clear     = 1'b1;
        #1;
        tests_run++; if (app_ready !== 1'b0 || kv_wr_en !== 1'b0)
            begin tests_failed++; $display("FAIL clear_prio ready=%b wr_en=%b want 0/0", app_ready, kv_wr_en); end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL clear_prio_count got %0d want 0", count); end
    endtask

`ifdef KV_SCHED_RING_EN
    task automatic test_full();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            app_valid = 1'b1;
            app_k     = DW'(i + 1);
            app_v     = DW'(i + 1);
            #1;
            tests_run++; if (app_ready !== 1'b1 || kv_wr_addr !== AW'(i % 4))
                begin tests_failed++; $display("FAIL ring_append i=%0d ready=%b addr=%0d want 1/%0d", i, app_ready, kv_wr_addr, i % 4); end
        end
        @(negedge clk);
        app_valid  = 1'b0;
        scan_start = 1'b1;
        #1;
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL ring_count got %0d want 4", count); end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            app_valid  = (c == 1);
            #1;
            if (c == 1) begin
                tests_run++; if (app_ready !== 1'b0) begin tests_failed++; $display("FAIL ring_protect got %b want 0", app_ready); end
            end
            if (c <= 4) begin
                tests_run++; if (kv_rd_en !== 1'b1 || kv_rd_addr !== AW'((c + 1) % 4))
                    begin tests_failed++; $display("FAIL ring_rd_addr c=%0d en=%b addr=%0d want 1/%0d", c, kv_rd_en, kv_rd_addr, (c + 1) % 4); end
            end
            if (c >= 2) begin
                tests_run++; if (out_valid !== 1'b1 || out_k !== DW'(c + 1))
                    begin tests_failed++; $display("FAIL ring_out c=%0d valid=%b k=%0d want 1/%0d", c, out_valid, out_k, c + 1); end
            end
        end
        app_valid = 1'b0;
    endtask
`else
    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            app_valid = 1'b1;
            app_k     = DW'(10 + i);
            #1;
            tests_run++; if (app_ready !== 1'b1 || kv_wr_addr !== AW'(i))
                begin tests_failed++; $display("FAIL full_append i=%0d ready=%b addr=%0d want 1/%0d", i, app_ready, kv_wr_addr, i); end
        end
        @(negedge clk);
        #1;
        tests_run++; if (app_ready !== 1'b0 || kv_wr_en !== 1'b0)
            begin tests_failed++; $display("FAIL full_blocked ready=%b wr_en=%b want 0/0", app_ready, kv_wr_en); end
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d want 4", count); end
        @(negedge clk);
        app_valid = 1'b0;
        #1;
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("FAIL full_count_hold got %0d want 4", count); end
    endtask
`endif

    task automatic test_reset_mid_scan();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_count got %0d want 0", count); end
        for (int c = 0; c < 3; c++) begin
            tests_run++; if ({out_valid, kv_rd_en, out_last, scan_done} !== 4'b0)
                begin tests_failed++; $display("FAIL rst_mid_quiet c=%0d got %b want 0000", c, {out_valid, kv_rd_en, out_last, scan_done}); end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_empty_scan();
        test_append();
        test_scan();
        test_clear_abort();
        test_clear_priority();
        test_full();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
